// File: rtl/avalon_line_burst_master.sv
// avalon_line_burst_master: moves one cache line per request as a single Avalon burst (refill or writeback).
// Optional watchdog abort enabled by defining AVALON_BURST_TIMEOUT_EN.
module avalon_line_burst_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic [7:0]          wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [7:0]          rd_idx,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   av_address,
  output logic [DATA_W/8-1:0] av_byteEnable,
  output logic                av_read,
  output logic                av_write,
  output logic [DATA_W-1:0]   av_writeData,
  output logic                av_beginBurstTransfer,
  output logic [7:0]          av_burstCount,
  input  logic                av_waitRequest,
  input  logic [DATA_W-1:0]   av_readData,
  input  logic                av_readDataValid
);
  localparam int OFF_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [7:0] BLEN8 = 8'(BURST_LEN);
  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BURST, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          beat_q;
  logic                first_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic [7:0]          rd_idx_q;
  logic                accept, cmd_ok, wr_ok, rd_beat, wr_last, rd_last, timeout;

  assign accept  = req_valid && state_q == IDLE;
  assign cmd_ok  = state_q == RD_CMD && !av_waitRequest;
  assign wr_ok   = state_q == WR_BURST && !av_waitRequest;
  assign wr_last = wr_ok && beat_q == LAST;
  // Beats past the line length are dropped so the index never exceeds BURST_LEN-1.
  assign rd_beat = (state_q == RD_CMD || state_q == RD_DATA) && av_readDataValid && beat_q != BLEN8;
  // Leave RD_DATA only once the last beat has been presented on rd_*.
  assign rd_last = state_q == RD_DATA && rd_valid_q && rd_idx_q == LAST;

  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (req_valid) state_d = req_write ? WR_BURST : RD_CMD;
      RD_CMD:   if (cmd_ok) state_d = RD_DATA;
      RD_DATA:  if (rd_last) state_d = DONE;
      WR_BURST: if (wr_last) state_d = DONE;
      default:  state_d = IDLE;
    endcase
    if (timeout) state_d = DONE;
  end

  always_comb begin
    req_ready             = state_q == IDLE;
    done                  = state_q == DONE;
    av_read               = state_q == RD_CMD;
    av_write              = state_q == WR_BURST;
    av_address            = (av_read || av_write) ? addr_q : '0;
    av_burstCount         = (av_read || av_write) ? BLEN8 : '0;
    av_byteEnable         = (av_read || av_write) ? '1 : '0;
    av_beginBurstTransfer = (av_read && first_q) || (av_write && beat_q == 8'd0);
    wr_idx                = av_write ? beat_q : '0;
    av_writeData          = av_write ? wr_data : '0;
    rd_data               = rd_data_q;
    rd_valid              = rd_valid_q;
    rd_idx                = rd_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      beat_q     <= '0;
      first_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      if (accept) addr_q <= req_addr & ~OFF_MASK;
      beat_q     <= accept ? 8'd0 : (wr_ok || rd_beat) ? beat_q + 8'd1 : beat_q;
      first_q    <= state_d == RD_CMD && state_q != RD_CMD;
      rd_valid_q <= rd_beat;
      if (rd_beat) rd_data_q <= av_readData;
      if (rd_beat) rd_idx_q <= beat_q;
    end
  end

`ifdef AVALON_BURST_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              err_q, active, progress;

  assign active   = state_q == RD_CMD || state_q == RD_DATA || state_q == WR_BURST;
  assign progress = cmd_ok || wr_ok || rd_beat;
  assign timeout  = active && !progress && wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1);
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= (accept || timeout || progress || !active) ? '0 : wdog_q + 1'b1;
      err_q  <= accept ? 1'b0 : timeout ? 1'b1 : err_q;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_line_burst_master.sv
// tb_avalon_line_burst_master: directed checks of refill, writeback, gaps, back-to-back and reset.
module tb_avalon_line_burst_master;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_write;
  logic [31:0] req_addr, wr_data, rd_data, av_address, av_writeData, av_readData;
  logic [7:0]  wr_idx, rd_idx, av_burstCount;
  logic [3:0]  av_byteEnable;
  logic        rd_valid, done, err, av_read, av_write, av_beginBurstTransfer;
  logic        av_waitRequest, av_readDataValid;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  assign wr_data = 32'h5A00_0000 + {24'd0, wr_idx};

  avalon_line_burst_master #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .wr_idx(wr_idx), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_idx(rd_idx), .done(done), .err(err), .av_address(av_address), .av_byteEnable(av_byteEnable),
    .av_read(av_read), .av_write(av_write), .av_writeData(av_writeData),
    .av_beginBurstTransfer(av_beginBurstTransfer), .av_burstCount(av_burstCount),
    .av_waitRequest(av_waitRequest), .av_readData(av_readData), .av_readDataValid(av_readDataValid)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
    tests++; if ({av_read, av_write, av_beginBurstTransfer, done, err, rd_valid} !== 6'b0) begin fails++; $display("FAIL reset_flags: got %b exp 000000", {av_read, av_write, av_beginBurstTransfer, done, err, rd_valid}); end
    tests++; if (av_address !== 32'h0 || av_burstCount !== 8'h0 || av_byteEnable !== 4'h0) begin fails++; $display("FAIL reset_bus: addr %h cnt %0d be %h exp 0", av_address, av_burstCount, av_byteEnable); end
    tests++; if (wr_idx !== 8'd0 || rd_idx !== 8'd0) begin fails++; $display("FAIL reset_idx: wr %0d rd %0d exp 0", wr_idx, rd_idx); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_refill;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1234; av_waitRequest = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests++; if (av_read !== 1'b1 || av_address !== 32'h0000_1220 || av_burstCount !== 8'd8 || av_byteEnable !== 4'hF) begin fails++; $display("FAIL refill_cmd: rd %b addr %h cnt %0d be %h exp 1 00001220 8 f", av_read, av_address, av_burstCount, av_byteEnable); end
    tests++; if (av_beginBurstTransfer !== 1'b1) begin fails++; $display("FAIL refill_begin_first: got %b exp 1", av_beginBurstTransfer); end
    for (int s = 2; s <= 11; s++) begin
      @(negedge clk);
      av_readDataValid = s <= 9;
      av_readData = 32'hA0 + 32'(s - 2);
      #1;
      if (s == 2) begin
        tests++; if (av_read !== 1'b0 || av_beginBurstTransfer !== 1'b0) begin fails++; $display("FAIL refill_cmd_drop: rd %b begin %b exp 0 0", av_read, av_beginBurstTransfer); end
      end
      if (s >= 3 && s <= 10) begin
        tests++; if (rd_valid !== 1'b1 || rd_idx !== 8'(s - 3) || rd_data !== 32'hA0 + 32'(s - 3)) begin fails++; $display("FAIL refill_beat: valid %b idx %0d data %h exp 1 %0d %h", rd_valid, rd_idx, rd_data, s - 3, 32'hA0 + 32'(s - 3)); end
      end
      if (s <= 10) begin
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL refill_done_early: slot %0d got %b exp 0", s, done); end
      end
      if (s == 11) begin
        tests++; if (done !== 1'b1 || rd_valid !== 1'b0) begin fails++; $display("FAIL refill_done: done %b rd_valid %b exp 1 0", done, rd_valid); end
      end
    end
    @(negedge clk); #1;
    tests++; if (done !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL refill_idle: done %b ready %b exp 0 1", done, req_ready); end
  endtask

  task automatic test_writeback;
    int idx = 0, wait_left = 3, acc = 0, guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0100;
    @(negedge clk);
    req_valid = 1'b0;
    while (idx < 8 && guard < 30) begin
      guard++;
      if (guard > 1) @(negedge clk);
      av_waitRequest = wait_left > 0;
      #1;
      tests++; if (av_write !== 1'b1 || wr_idx !== 8'(idx) || av_writeData !== 32'h5A00_0000 + 32'(idx)) begin fails++; $display("FAIL wb_beat: wr %b idx %0d data %h exp 1 %0d %h", av_write, wr_idx, av_writeData, idx, 32'h5A00_0000 + 32'(idx)); end
      tests++; if (av_address !== 32'h100 || av_burstCount !== 8'd8 || av_beginBurstTransfer !== (idx == 0)) begin fails++; $display("FAIL wb_hold: addr %h cnt %0d begin %b exp 00000100 8 %b", av_address, av_burstCount, av_beginBurstTransfer, idx == 0); end
      if (!av_waitRequest) begin idx++; acc++; wait_left = (idx == 5) ? 1 : 0; end
      else wait_left--;
    end
    tests++; if (acc !== 8) begin fails++; $display("FAIL wb_accepted: got %0d exp 8", acc); end
    @(negedge clk);
    av_waitRequest = 1'b0;
    #1;
    tests++; if (av_write !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL wb_done: wr %b done %b exp 0 1", av_write, done); end
    @(negedge clk); #1;
    tests++; if (done !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL wb_idle: done %b ready %b exp 0 1", done, req_ready); end
  endtask

  task automatic test_read_gaps;
    int sent = 1, pend_i = 0;
    logic pend_v = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFFFF_FFE7;
    @(negedge clk);
    req_valid = 1'b0; av_waitRequest = 1'b1;
    #1;
    tests++; if (av_read !== 1'b1 || av_beginBurstTransfer !== 1'b1 || av_address !== 32'hFFFF_FFE0) begin fails++; $display("FAIL gaps_cmd: rd %b begin %b addr %h exp 1 1 ffffffe0", av_read, av_beginBurstTransfer, av_address); end
    @(negedge clk);
    av_waitRequest = 1'b0; av_readDataValid = 1'b1; av_readData = 32'hB0;
    #1;
    tests++; if (av_read !== 1'b1 || av_beginBurstTransfer !== 1'b0) begin fails++; $display("FAIL gaps_cmd_held: rd %b begin %b exp 1 0", av_read, av_beginBurstTransfer); end
    for (int s = 3; s <= 18; s++) begin
      @(negedge clk);
      av_readDataValid = (s % 2 == 0) && sent < 8;
      av_readData = 32'hB0 + 32'(sent);
      #1;
      tests++; if (rd_valid !== pend_v || (pend_v && (rd_idx !== 8'(pend_i) || rd_data !== 32'hB0 + 32'(pend_i)))) begin fails++; $display("FAIL gaps_beat: slot %0d valid %b idx %0d data %h exp %b %0d %h", s, rd_valid, rd_idx, rd_data, pend_v, pend_i, 32'hB0 + 32'(pend_i)); end
      tests++; if (done !== (s == 18)) begin fails++; $display("FAIL gaps_done: slot %0d got %b exp %b", s, done, s == 18); end
      pend_v = av_readDataValid; pend_i = sent;
      if (av_readDataValid) sent++;
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040; av_waitRequest = 1'b0;
    for (int s = 1; s <= 9; s++) begin
      @(negedge clk);
      if (s == 9) begin req_write = 1'b0; req_addr = 32'h0000_0080; end
      #1;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_busy: slot %0d got %b exp 0", s, req_ready); end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b exp 1", done); end
    @(negedge clk); #1;
    tests++; if (req_ready !== 1'b1 || av_write !== 1'b0 || av_read !== 1'b0) begin fails++; $display("FAIL b2b_gap: ready %b wr %b rd %b exp 1 0 0", req_ready, av_write, av_read); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests++; if (av_read !== 1'b1 || av_address !== 32'h80 || req_ready !== 1'b0) begin fails++; $display("FAIL b2b_second: rd %b addr %h ready %b exp 1 00000080 0", av_read, av_address, req_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0200; av_waitRequest = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (wr_idx !== 8'd3 || av_write !== 1'b1) begin fails++; $display("FAIL rstmid_pre: idx %0d wr %b exp 3 1", wr_idx, av_write); end
    rst = 1'b1;
    @(negedge clk); #1;
    tests++; if (av_write !== 1'b0 || req_ready !== 1'b1 || wr_idx !== 8'd0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_post: wr %b ready %b idx %0d done %b exp 0 1 0 0", av_write, req_ready, wr_idx, done); end
    rst = 1'b0;
    @(negedge clk); #1;
    tests++; if (done !== 1'b0 || av_write !== 1'b0) begin fails++; $display("FAIL rstmid_nodone: done %b wr %b exp 0 0", done, av_write); end
  endtask

`ifdef AVALON_BURST_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0300; av_waitRequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int s = 1; s <= 16; s++) begin
      if (s > 1) @(negedge clk);
      #1;
      tests++; if (av_read !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL to_wait: slot %0d rd %b done %b exp 1 0", s, av_read, done); end
    end
    @(negedge clk); #1;
    tests++; if (av_read !== 1'b0 || done !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL to_abort: rd %b done %b err %b exp 0 1 1", av_read, done, err); end
    @(negedge clk);
    req_valid = 1'b1; av_waitRequest = 1'b0;
    #1;
    tests++; if (err !== 1'b1 || req_ready !== 1'b1) begin fails++; $display("FAIL to_sticky: err %b ready %b exp 1 1", err, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_clear: err %b exp 0", err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    av_waitRequest = 1'b0; av_readData = '0; av_readDataValid = 1'b0;
    test_reset();
    test_refill();
    test_writeback();
    test_read_gaps();
    test_back_to_back();
    test_reset_mid();
`ifdef AVALON_BURST_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/avalon_line_burst_master.md
Name: avalon_line_burst_master

Overview:
- Bridges the cache controller's line-refill and line-writeback requests onto the Avalon memory bus.
- Drives the Avalon master signal group: address, byteEnable, read, write, writeData, beginBurstTransfer, burstCount.
- One request moves one full cache line as a single fixed-length burst.
- Sits directly downstream of the cache controller and directly upstream of the memory-side Avalon fabric.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteEnable width is DATA_W/8
- BURST_LEN, 8, words per cache line; legal range 1..255; power of two
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  cache line request valid
- req_ready  out  1  block idle and able to accept a request
- req_write  in  1  1 = writeback, 0 = refill
- req_addr  in  ADDR_W  line address; low log2(BURST_LEN*DATA_W/8) bits ignored
- wr_idx  out  8  index of the writeback word the cache must present now
- wr_data  in  DATA_W  cache line word at wr_idx; combinational from the cache line buffer
- rd_data  out  DATA_W  refill word
- rd_valid  out  1  rd_data valid this cycle
- rd_idx  out  8  word index of rd_data
- done  out  1  one-cycle pulse when the line transfer completes
- err  out  1  transfer aborted by watchdog
- av_address  out  ADDR_W
- av_byteEnable  out  DATA_W/8
- av_read  out  1
- av_write  out  1
- av_writeData  out  DATA_W
- av_beginBurstTransfer  out  1
- av_burstCount  out  8
- av_waitRequest  in  1
- av_readData  in  DATA_W
- av_readDataValid  in  1

Behaviour:
- Reset values: req_ready=1; all other outputs 0. FSM in IDLE. Beat counters cleared.
- States: IDLE, RD_CMD, RD_DATA, WR_BURST, DONE.
- IDLE
  - req_ready=1.
  - On req_valid&req_ready: latch req_addr with the line-offset bits cleared and latch req_write.
  - Go to WR_BURST if req_write, else RD_CMD.
  - av_readDataValid is ignored in IDLE.
- RD_CMD
  - Drive av_read=1, av_address=latched line address, av_burstCount=BURST_LEN, av_byteEnable all ones.
  - av_beginBurstTransfer=1 only in the first cycle of the state.
  - All outputs held stable while av_waitRequest=1.
  - Cycle with av_waitRequest=0: command accepted; next cycle av_read=0 and state is RD_DATA.
- RD_DATA
  - Each av_readDataValid beat is registered: rd_data=av_readData, rd_valid=1, rd_idx=beat count. Latency is exactly 1 cycle.
  - The beat counter increments per beat.
  - After beat BURST_LEN-1: go to DONE.
  - Beats may arrive back-to-back or with gaps.
  - Beats arriving in the same cycle as command acceptance are counted.
- WR_BURST
  - Drive av_write=1, av_writeData=wr_data, wr_idx=beat count, av_address=line address, av_burstCount=BURST_LEN, av_byteEnable all ones.
  - av_address and av_burstCount are constant for the whole burst.
  - av_beginBurstTransfer=1 only while wr_idx=0 and not yet accepted.
  - A beat is accepted when av_waitRequest=0, after which wr_idx increments.
  - After acceptance of beat BURST_LEN-1: av_write drops next cycle; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. req_ready returns to 1 the cycle after done.
- No new request is accepted between acceptance and done.
- wr_idx and rd_idx wrap never; the counters are sized for 255 beats.
- rst asserted mid-transfer: next edge returns to reset values. The Avalon burst is abandoned (system reset is global). No done pulse.
- Simultaneous av_waitRequest=0 and av_readDataValid in RD_CMD: both are processed in that cycle.

Optional Feature:
- Macro: AVALON_BURST_TIMEOUT_EN
- Defined:
  - A watchdog counter runs in RD_CMD, RD_DATA and WR_BURST.
  - The counter clears on any accepted command, accepted write beat, or read beat.
  - On reaching TIMEOUT_CYCLES: drop av_read/av_write, set err=1, pulse done, return to IDLE.
  - err is sticky until the next accepted request.
  - Late av_readDataValid beats in IDLE are ignored.
- Not defined: no counter is built and err is tied to 0.

Test Plan:
- Refill, req_addr=0x0000_1234, BURST_LEN=8, no waits, 8 consecutive readDataValid beats 0xA0..0xA7
  -> av_address=0x0000_1220, av_burstCount=8, av_beginBurstTransfer for 1 cycle; rd_idx 0..7 carrying 0xA0..0xA7 one cycle after each beat; done one cycle after the last rd_valid.
- Writeback, req_addr=0x100, av_waitRequest high for 3 cycles on beat 0 and for 1 cycle on beat 5
  -> av_writeData follows wr_idx 0..7; address, burstCount and data held stable during waits; exactly 8 accepted beats; done pulse.
- Read beats with gaps (valid on alternate cycles)
  -> rd_idx 0..7 with no skips or duplicates; done only after the 8th beat.
- req_valid held high continuously
  -> a second request is accepted only the cycle after done; req_ready=0 throughout the first transfer.
- rst asserted during WR_BURST at wr_idx=3
  -> next cycle av_write=0, req_ready=1, wr_idx=0, no done pulse.
- With AVALON_BURST_TIMEOUT_EN and TIMEOUT_CYCLES=16, av_waitRequest held high in RD_CMD
  -> av_read drops after 16 cycles, err=1, done pulses; err clears on the next request.
